// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache for the core data port.
// Read hits complete combinationally; misses and stores stall until main memory acks.
module data_cache #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_ready,
    input  logic        inv_all,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = 30 - IDX;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t            state_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];
    logic              mem_req_q;
    logic              mem_we_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       hit_q;
    logic [31:0]       miss_q;

    logic [IDX-1:0]    idx;
    logic [TAG_W-1:0]  tag_in;
    logic              hit;
    logic              rd_hit;
    logic              fill_done;
    logic              wr_done;
    logic [1:0]        unused_addr_lsb;

    assign idx             = core_addr[IDX+1:2];
    assign tag_in          = core_addr[31:IDX+2];
    assign unused_addr_lsb = core_addr[1:0];

    assign hit       = core_req && valid_q[idx] && (tag_q[idx] == tag_in);
    assign rd_hit    = (state_q == IDLE) && core_req && !core_we && hit;
    assign fill_done = (state_q == FILL) && mem_ack;
    assign wr_done   = (state_q == WRITE) && mem_ack;

    assign core_ready = rd_hit || fill_done || wr_done;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = core_wdata;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

    always_comb begin
        core_rdata = 32'h0;
        if (rd_hit)
            core_rdata = data_q[idx];
        else if (fill_done)
            core_rdata = mem_rdata;
    end

    // The core holds its address stable while stalled, so idx/tag_in still
    // name the line being filled or written when the ack arrives.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[idx]  <= tag_in;
            data_q[idx] <= mem_rdata;
        end else if (wr_done && hit) begin
            data_q[idx] <= core_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'h0;
            hit_q      <= 32'h0;
            miss_q     <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (core_req) begin
                        if (core_we) begin
                            state_q    <= WRITE;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= {core_addr[31:2], 2'b00};
                        end else if (hit) begin
                            if (hit_q != 32'hFFFF_FFFF)
                                hit_q <= hit_q + 32'd1;
                        end else begin
                            if (miss_q != 32'hFFFF_FFFF)
                                miss_q <= miss_q + 32'd1;
                            state_q    <= FILL;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {core_addr[31:2], 2'b00};
                        end
                    end else if (inv_all) begin
                        valid_q <= '0;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid_q[idx] <= 1'b1;
                        state_q      <= IDLE;
                        mem_req_q    <= 1'b0;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: bench-driven memory responder with programmable
// ack latency, expected values computed by hand.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst_b;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_ready;
    logic        inv_all;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_chk  = 0;
    int n_fail = 0;

    data_cache #(.LINES(16)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ready (core_ready),
        .inv_all    (inv_all),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1. Presents one request and plays memory: ack is
    // raised 'lat' cycles after mem_req is first seen. cyc = cycles until core_ready.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, input logic [31:0] mrd, input logic inv,
                          output int cyc, output logic [31:0] rd, output logic [31:0] maddr,
                          output logic mwe, output logic [31:0] mwd, output logic mreq_seen);
        int first;
        logic done;
        core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata; inv_all = inv;
        first = -1; done = 1'b0; cyc = -1; rd = '0; maddr = '0; mwe = 1'b0; mwd = '0; mreq_seen = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mem_req) begin
                if (first < 0) first = c;
                mreq_seen = 1'b1; maddr = mem_addr; mwe = mem_we; mwd = mem_wdata;
                if (c - first == lat) begin
                    mem_ack = 1'b1; mem_rdata = mrd;
                end
            end
            #4;
            if (core_ready) begin
                done = 1'b1; cyc = c; rd = core_rdata;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = '0;
        end
        core_req = 1'b0; core_we = 1'b0; inv_all = 1'b0;
        chk("access_done", {31'b0, done}, 32'd1);
    endtask

    int          cyc;
    logic [31:0] rd, maddr, mwd;
    logic        mwe, mseen;

    initial begin
        rst_b = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        inv_all = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_ready", {31'b0, core_ready}, 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
        @(posedge clk); #1; rst_b = 1'b1;
        @(posedge clk); #1;

        // cold miss, then hit
        access(1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("miss_latency", cyc, 32'd4);
        chk("miss_rdata", rd, 32'hDEADBEEF);
        chk("miss_addr", maddr, 32'h40);
        chk("miss_we", {31'b0, mwe}, 32'd0);
        chk("miss_count1", miss_count, 32'd1);
        access(1'b0, 32'h40, 32'h0, 3, 32'h0, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("hit_latency", cyc, 32'd0);
        chk("hit_rdata", rd, 32'hDEADBEEF);
        chk("hit_no_memreq", {31'b0, mseen}, 32'd0);
        chk("hit_count1", hit_count, 32'd1);
        #4 chk("hit_memreq_after", {31'b0, mem_req}, 32'd0);
        @(posedge clk); #1;

        // write-through to a cached line
        access(1'b1, 32'h40, 32'h12345678, 2, 32'h0, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("wr_latency", cyc, 32'd3);
        chk("wr_we", {31'b0, mwe}, 32'd1);
        chk("wr_addr", maddr, 32'h40);
        chk("wr_wdata", mwd, 32'h12345678);
        chk("wr_no_miss", miss_count, 32'd1);
        access(1'b0, 32'h40, 32'h0, 2, 32'h0, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("wr_hit_latency", cyc, 32'd0);
        chk("wr_hit_rdata", rd, 32'h12345678);
        chk("hit_count2", hit_count, 32'd2);

        // store to uncached line does not allocate
        access(1'b1, 32'h83, 32'hCAFEF00D, 1, 32'h0, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("wr2_latency", cyc, 32'd2);
        chk("wr2_addr_aligned", maddr, 32'h80);
        access(1'b0, 32'h80, 32'h0, 2, 32'hCAFEF00D, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("noalloc_latency", cyc, 32'd3);
        chk("noalloc_rdata", rd, 32'hCAFEF00D);
        chk("miss_count2", miss_count, 32'd2);

        // 0x40 and 0x80 alias to index 0
        access(1'b0, 32'h40, 32'h0, 1, 32'h12345678, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("alias_a_latency", cyc, 32'd2);
        chk("alias_a_rdata", rd, 32'h12345678);
        chk("miss_count3", miss_count, 32'd3);
        access(1'b0, 32'h80, 32'h0, 1, 32'h000055AA, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("alias_b_latency", cyc, 32'd2);
        chk("miss_count4", miss_count, 32'd4);
        access(1'b0, 32'h80, 32'h0, 1, 32'h0, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("alias_b_hit", cyc, 32'd0);
        chk("alias_b_rdata", rd, 32'h000055AA);
        chk("hit_count3", hit_count, 32'd3);

        // fill index 1, invalidate in idle, then refill
        access(1'b0, 32'h44, 32'h0, 1, 32'h44444444, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("miss_count5", miss_count, 32'd5);
        inv_all = 1'b1;
        @(posedge clk); #1;
        inv_all = 1'b0;
        access(1'b0, 32'h44, 32'h0, 1, 32'h44440000, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("inv_miss_latency", cyc, 32'd2);
        chk("inv_rdata", rd, 32'h44440000);
        chk("miss_count6", miss_count, 32'd6);

        // inv_all alongside a request is dropped
        access(1'b0, 32'h44, 32'h0, 1, 32'h0, 1'b1, cyc, rd, maddr, mwe, mwd, mseen);
        chk("inv_req_hit", cyc, 32'd0);
        access(1'b0, 32'h44, 32'h0, 1, 32'h0, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("inv_dropped_hit", cyc, 32'd0);
        chk("inv_dropped_rdata", rd, 32'h44440000);
        chk("hit_count5", hit_count, 32'd5);

        // async reset mid-fill
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h48;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("fill_memreq", {31'b0, mem_req}, 32'd1);
        #2 rst_b = 1'b0;
        #1;
        chk("arst_memreq", {31'b0, mem_req}, 32'd0);
        chk("arst_memwe", {31'b0, mem_we}, 32'd0);
        chk("arst_hits", hit_count, 32'd0);
        chk("arst_misses", miss_count, 32'd0);
        core_req = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
        #4 chk("stray_ack_ready", {31'b0, core_ready}, 32'd0);
        chk("stray_ack_rdata", core_rdata, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = '0;
        chk("stray_ack_memreq", {31'b0, mem_req}, 32'd0);
        access(1'b0, 32'h44, 32'h0, 1, 32'h11112222, 1'b0, cyc, rd, maddr, mwe, mwd, mseen);
        chk("post_rst_miss", cyc, 32'd2);
        chk("post_rst_rdata", rd, 32'h11112222);
        chk("post_rst_misses", miss_count, 32'd1);
        chk("post_rst_hits", hit_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate word cache between the single-cycle MIPS core's data port and a multi-cycle main data memory.
- Read hits return in the request cycle. Misses and all writes stall the core through core_ready until main memory acknowledges.
- Also provides hit/miss performance counters and a whole-cache invalidate.

Parameters:
- LINES, 16, number of one-word lines; power of two, minimum 2.
- IDX, $clog2(LINES), index width (derived, not overridable).
- TAG_W, 30-IDX, tag width.

Ports:
- clk  input  1  rising-edge clock
- rst_b  input  1  asynchronous active-low reset
- core_req  input  1  core data access valid this cycle
- core_we  input  1  1 = store word, 0 = load word
- core_addr  input  32  byte address; bits [1:0] ignored (word aligned)
- core_wdata  input  32  store data; byte0 = [31:24] (big-endian, core byte order)
- core_rdata  output  32  load data; byte0 = [31:24]
- core_ready  output  1  access completes this cycle; core holds req/we/addr/wdata stable while low
- inv_all  input  1  clear all valid bits; honoured only in IDLE
- mem_req  output  1  main-memory request
- mem_we  output  1  main-memory write
- mem_addr  output  32  word-aligned address ({core_addr[31:2],2'b00})
- mem_wdata  output  32  write data (= core_wdata)
- mem_rdata  input  32  read data, valid with mem_ack
- mem_ack  input  1  one-cycle completion pulse from memory
- hit_count  output  32  saturating read-hit counter
- miss_count  output  32  saturating read-miss counter

Behaviour:
- Address split: index = core_addr[IDX+1:2]; tag = core_addr[31:IDX+2].
- Storage: valid[LINES], tag[LINES][TAG_W], data[LINES][32].
- hit = core_req & valid[index] & (tag[index] == addr tag).
- Reset (async, rst_b=0):
  - state=IDLE, all valid=0, counters=0.
  - mem_req=0, mem_we=0, core_ready=0, core_rdata=0.
  - Reset mid-FILL or mid-WRITE abandons the transaction. A late mem_ack after reset is ignored in IDLE.
- State machine:
  - IDLE:
    - Read hit: core_rdata=data[index], core_ready=1 combinationally; hit_count+1 at clock edge; stay IDLE.
    - Read miss: core_ready=0; miss_count+1; go to FILL.
    - core_req & core_we: core_ready=0; go to WRITE.
    - No request: core_ready=0.
    - inv_all with no core_req: all valid cleared next edge.
    - inv_all with core_req: request is served, invalidate is dropped. inv_all must be re-asserted.
  - FILL:
    - mem_req=1, mem_we=0, mem_addr registered on IDLE exit.
    - On mem_ack: core_rdata=mem_rdata, core_ready=1 same cycle; line written (valid=1, tag, data) at that edge; go to IDLE.
  - WRITE:
    - mem_req=1, mem_we=1, mem_wdata=core_wdata.
    - On mem_ack: core_ready=1. If the line hits, data[index] is updated at that edge, otherwise the cache is unchanged (no allocate). Go to IDLE.
- Latency:
  - Read hit: 0 extra cycles.
  - Read miss: 1 + memory latency. Memory sees mem_req from the cycle after the miss.
  - Write: the same as a read miss.
- mem_req stays high until and including the mem_ack cycle, and deasserts the cycle after.
- mem_ack outside FILL/WRITE is ignored.
- Counters saturate at 32'hFFFF_FFFF. Writes do not count.
- Back-to-back: a request presented in the cycle after core_ready is treated as new, with a fresh lookup reflecting any update from the previous edge.
- IDX wrap: addresses differing only above bit IDX+1 alias to one line; the newest fill replaces the line.

Test Plan:
- Reset, then read 0x0000_0040 (miss), memory acks after 3 cycles with 0xDEADBEEF -> core_ready 4 cycles after req, core_rdata=0xDEADBEEF, miss_count=1. Repeat read -> core_ready same cycle, hit_count=1, mem_req stays 0.
- Write 0x0000_0040 := 0x12345678 on the cached line -> mem_req/mem_we high until ack, mem_addr=0x40. Following read hits with 0x12345678.
- Write 0x0000_0080 (uncached) -> memory written; next read of 0x80 misses (no allocate).
- Aliasing, LINES=16: read 0x40 (fill A), read 0x80 (index 0, fill B), read 0x40 -> miss again, miss_count increments each time.
- inv_all in IDLE after fills -> next read of 0x40 misses. inv_all together with core_req -> request is served, valid bits untouched.
- Assert rst_b=0 during FILL with mem_req high -> mem_req=0 immediately (async), all valid=0, counters=0; a stray mem_ack afterwards causes no response.
